// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI link endpoints.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // Mode number is {cpol, cpha}, matching the master side.
  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, with a history flop
// producing single-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  // Shift the pin through the chain; history holds the previous output level.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_in};
    hist_d = sync_q[STAGES-1];
  end

  // Chain and history registers; reset to the pin's idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~hist_q;
  assign fall = ~q & hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled pins, all four CPOL/CPHA modes, MSB-first bytes,
// one-byte transmit holding buffer with valid/ready fill.
//
// state  | meaning
// IDLE   | CS high; SCK edges ignored, waiting for CS fall
// ACTIVE | CS low; sampling MOSI and shifting MISO on detected SCK edges
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES   = 2,
  parameter logic [SPI_BYTE_W-1:0] UNDERRUN_BYTE = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sck_in,
  input  logic                  cs_n_in,
  input  logic                  mosi_in,
  output logic                  miso_out,
  output logic                  miso_oe,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun,
  output logic                  frame_err
);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst_n(rst_n), .d_in(sck_in),
    .q(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .d_in(cs_n_in),
    .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  // MOSI goes through the same depth so it lines up with the SCK edge pulses.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  // Advance the MOSI synchronizer chain.
  always_comb mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e            state_q, state_d;
  spi_mode_e             mode_q, mode_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  first_q, first_d;
  logic [SPI_BYTE_W-1:0] rx_sh_q, rx_sh_d;
  logic [SPI_BYTE_W-1:0] tx_sh_q, tx_sh_d;
  logic [SPI_BYTE_W-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  frame_err_q, frame_err_d;

  logic sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_start, cs_stop, load;

  // Edge classification against the mode latched at CS assertion.
  always_comb begin
    sck_edge    = sck_rise | sck_fall;
    lead_edge   = sck_edge && (sck_s != mode_q[1]);
    trail_edge  = sck_edge && (sck_s == mode_q[1]);
    sample_edge = mode_q[0] ? trail_edge : lead_edge;
    shift_edge  = mode_q[0] ? lead_edge  : trail_edge;
    cs_start    = (cs_rise | cs_fall) && !cs_s;
    cs_stop     = (cs_rise | cs_fall) && cs_s;
  end

  // Frame FSM, shift registers and holding-buffer bookkeeping.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    bit_cnt_d   = bit_cnt_q;
    first_d     = first_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_start) begin
          state_d   = ACTIVE;
          mode_d    = spi_mode_e'({cpol, cpha});
          bit_cnt_d = 3'd0;
          first_d   = 1'b1;
          rx_sh_d   = '0;
          load      = 1'b1;
        end
      end
      ACTIVE: begin
        if (sample_edge) begin
          rx_sh_d   = {rx_sh_q[SPI_BYTE_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_sh_q[SPI_BYTE_W-2:0], mosi_s};
            rx_valid_d = 1'b1;
            // cpha=0 needs the next bit 7 on the pin before the next leading edge.
            if (!mode_q[0]) load = 1'b1;
          end
        end
        if (shift_edge) begin
          if (bit_cnt_q == 3'd0) begin
            // cpha=1: the byte's first leading edge presents bit 7; the frame's
            // first byte was already loaded at CS assertion.
            if (mode_q[0]) begin
              if (!first_q) load = 1'b1;
              first_d = 1'b0;
            end
          end else begin
            tx_sh_d = {tx_sh_q[SPI_BYTE_W-2:0], 1'b0};
          end
        end
        if (cs_stop) begin
          // Check the post-sample count so a byte completing this cycle is not an error.
          if (bit_cnt_d != 3'd0) frame_err_d = 1'b1;
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          rx_sh_d   = '0;
          load      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (hold_full_q) begin
        tx_sh_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_sh_d    = UNDERRUN_BYTE;
        underrun_d = 1'b1;
      end
    end

    // Accept uses the registered ready, so a same-cycle load sees the old content.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      mode_q      <= SPI_MODE0;
      bit_cnt_q   <= 3'd0;
      first_q     <= 1'b0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      bit_cnt_q   <= bit_cnt_d;
      first_q     <= first_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso_out    = tx_sh_q[SPI_BYTE_W-1];
  assign miso_oe     = (state_q == ACTIVE);
  assign busy        = (state_q == ACTIVE);
  assign tx_ready    = !hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-banged SPI master drives the pins,
// received bytes are scoreboarded against the rx_valid strobe, MISO bytes
// are collected by the master and compared against queued expectations.
module tb_spi_slave;

  localparam int HP = 8;  // SCK half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpol, cpha;
  logic       sck_in, cs_n_in, mosi_in;
  logic       miso_out, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, tx_underrun, frame_err;

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(2), .UNDERRUN_BYTE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
    .sck_in(sck_in), .cs_n_in(cs_n_in), .mosi_in(mosi_in),
    .miso_out(miso_out), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .tx_underrun(tx_underrun), .frame_err(frame_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];

  int   rx_cnt = 0, udr_cnt = 0, ferr_cnt = 0, rdy_rise = 0;
  logic oe_seen = 1'b0;
  logic rdy_prev = 1'b1;

  // Output monitor: pops the rx scoreboard on each strobe, counts pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rx_cnt++;
        chk("rx_queue_nonempty", 32'(exp_rx_q.size() != 0), 32'd1);
        if (exp_rx_q.size() != 0) chk("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
      end
      if (tx_underrun) udr_cnt++;
      if (frame_err) ferr_cnt++;
      if (miso_oe) oe_seen = 1'b1;
      if (tx_ready && !rdy_prev) rdy_rise++;
      rdy_prev = tx_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_buf(input logic [7:0] b);
    int t = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && t < 200) begin
      cyc(1);
      t++;
    end
    chk("load_buf_timeout", 32'(t < 200), 32'd1);
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic cs_low(input logic [1:0] mode);
    cpol   = mode[1];
    cpha   = mode[0];
    sck_in = mode[1];
    cyc(HP);
    cs_n_in = 1'b0;
    cyc(HP);
  endtask

  task automatic cs_high();
    cyc(HP);
    cs_n_in = 1'b1;
    cyc(3 * HP);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!cpha) begin
        mosi_in = tx[i];
        cyc(HP);
        rx[i]  = miso_out;
        sck_in = ~cpol;
        cyc(HP);
        sck_in = cpol;
      end else begin
        cyc(HP);
        sck_in  = ~cpol;
        mosi_in = tx[i];
        cyc(HP);
        rx[i]  = miso_out;
        sck_in = cpol;
      end
    end
  endtask

  // Full byte: expectations are queued before the bits go out.
  task automatic send_byte(input logic [7:0] tx, input logic [7:0] miso_exp, input string tag);
    logic [7:0] rx;
    exp_rx_q.push_back(tx);
    exp_miso_q.push_back(miso_exp);
    xfer_bits(tx, 8, rx);
    chk(tag, 32'(rx), 32'(exp_miso_q.pop_front()));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 32'({miso_out, miso_oe, tx_ready, rx_valid, busy, tx_underrun, frame_err}),
        32'b0010000);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'h00);
  endtask

  initial begin
    int   rx0, udr0, ferr0, rdy0;
    logic [7:0] junk;
    rst_n = 1'b0; cpol = 1'b0; cpha = 1'b0;
    sck_in = 1'b0; cs_n_in = 1'b1; mosi_in = 1'b0;
    tx_data = '0; tx_valid = 1'b0;
    cyc(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    cyc(5);

    // Mode 0: 0xA5 in, buffered 0x3C out.
    load_buf(8'h3C);
    chk("m0_tx_ready_full", 32'(tx_ready), 32'd0);
    rx0 = rx_cnt;
    cs_low(2'b00);
    chk("m0_busy_oe", 32'({busy, miso_oe}), 32'b11);
    send_byte(8'hA5, 8'h3C, "m0_miso");
    cs_high();
    chk("m0_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
    chk("m0_idle_busy_oe", 32'({busy, miso_oe}), 32'b00);

    // Mode 3: two bytes, second buffer byte arrives mid-frame.
    load_buf(8'h55);
    rx0 = rx_cnt; udr0 = udr_cnt; rdy0 = rdy_rise;
    cs_low(2'b11);
    load_buf(8'hF0);
    send_byte(8'h12, 8'h55, "m3_miso0");
    send_byte(8'h34, 8'hF0, "m3_miso1");
    cs_high();
    chk("m3_rx_pulses", 32'(rx_cnt - rx0), 32'd2);
    chk("m3_tx_ready_rises", 32'(rdy_rise - rdy0), 32'd2);
    chk("m3_no_underrun", 32'(udr_cnt - udr0), 32'd0);

    // Mode 1: empty buffer at CS assertion.
    chk("m1_tx_ready_empty", 32'(tx_ready), 32'd1);
    udr0 = udr_cnt;
    cs_low(2'b01);
    send_byte(8'hC3, 8'h00, "m1_miso_underrun");
    cs_high();
    chk("m1_underrun_pulses", 32'(udr_cnt - udr0), 32'd1);

    // Mode 2: CS released after 5 bits.
    rx0 = rx_cnt; ferr0 = ferr_cnt;
    cs_low(2'b10);
    xfer_bits(8'hB7, 5, junk);
    cs_high();
    chk("m2_frame_err", 32'(ferr_cnt - ferr0), 32'd1);
    chk("m2_no_rx", 32'(rx_cnt - rx0), 32'd0);
    chk("m2_busy_oe", 32'({busy, miso_oe}), 32'b00);
    chk("m2_rx_data_kept", 32'(rx_data), 32'hC3);

    // Reset mid-byte in mode 0, then a clean frame.
    load_buf(8'h99);
    cs_low(2'b00);
    xfer_bits(8'h5A, 3, junk);
    rst_n = 1'b0;
    cs_n_in = 1'b1;
    sck_in = 1'b0;
    cyc(2);
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    cyc(10);
    load_buf(8'h7E);
    rx0 = rx_cnt;
    cs_low(2'b00);
    send_byte(8'h81, 8'h7E, "post_reset_miso");
    cs_high();
    chk("post_reset_rx_pulses", 32'(rx_cnt - rx0), 32'd1);

    // SCK activity with CS high must be ignored.
    rx0 = rx_cnt;
    oe_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sck_in  = ~sck_in;
      mosi_in = 1'($urandom_range(0, 1));
      cyc(4);
    end
    cyc(10);
    chk("idle_sck_no_rx", 32'(rx_cnt - rx0), 32'd0);
    chk("idle_sck_no_oe", 32'(oe_seen), 32'd0);

    chk("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Single-clock SPI responder for the far end of the `spi_master` link.
- Oversamples the external SCK, CS_n and MOSI pins in the `clk` domain and supports all four CPOL/CPHA modes.
- Shifts bytes MSB-first, presents each received byte with a one-cycle strobe, and drives MISO from a one-byte transmit holding buffer filled through a valid/ready handshake.
- Sits between the board-level SPI pins and the local register/FIFO logic.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for `sck_in`, `cs_n_in`, `mosi_in` (minimum 2).
- `UNDERRUN_BYTE`, 8'h00: byte shifted out when the holding buffer is empty.

Ports:
- `clk`  in  1  system clock; must be at least 8× the SCK frequency.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpol`  in  1  SCK idle level; sampled at CS assertion.
- `cpha`  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled at CS assertion.
- `sck_in`  in  1  SPI clock pin, asynchronous.
- `cs_n_in`  in  1  chip select pin, active low, asynchronous.
- `mosi_in`  in  1  master-out data pin, asynchronous.
- `miso_out`  out  1  slave-out data.
- `miso_oe`  out  1  output enable for the MISO pad; high while selected.
- `tx_data`  in  8  next byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  holding buffer is empty.
- `rx_data`  out  8  last received byte.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` is new.
- `busy`  out  1  frame in progress.
- `tx_underrun`  out  1  one-cycle pulse: a byte was started with the buffer empty.
- `frame_err`  out  1  one-cycle pulse: CS deasserted with a partial byte.

## Operation
- Synchronizers: `SYNC_STAGES` flops per input, plus one history flop on SCK and CS for edge detection.
- Leading edge: SCK leaves the `cpol` level. Trailing edge: SCK returns to it.
- State machine IDLE → ACTIVE:
  - IDLE → ACTIVE on synchronized CS falling edge.
    - Latch `cpol`/`cpha`; clear `bit_cnt` (3 bits).
    - Load the shift-out register from the holding buffer, or from `UNDERRUN_BYTE` with a `tx_underrun` pulse if the buffer is empty.
    - Assert `miso_oe` and `busy`.
  - ACTIVE, sample edge (leading if cpha=0, trailing if cpha=1):
    - Shift `mosi` into the rx shift register; increment `bit_cnt`.
    - On the 8th bit, copy to `rx_data` and pulse `rx_valid` on the following cycle.
  - ACTIVE, shift edge (the opposite edge):
    - Advance `miso_out` to the next bit.
    - When cpha=1, the first leading edge presents bit 7 instead of shifting.
    - After a byte completes, the next byte is loaded at the first shift edge of the new byte (cpha=1), or immediately after the 8th sample (cpha=0).
  - ACTIVE → IDLE on synchronized CS rising edge.
    - If `bit_cnt` ≠ 0: pulse `frame_err` and discard the partial rx byte.
    - Drop `miso_oe` and `busy`.
    - The holding buffer is retained.
- Holding buffer: a `tx_valid && tx_ready` transfer fills it and clears `tx_ready`. The shift-register load empties it and sets `tx_ready` in the next cycle.
- The mode inputs are ignored while ACTIVE.
- SCK edges while in IDLE are ignored.

## Timing
- Reset values:
  - `miso_out`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `busy`=0, `tx_underrun`=0, `frame_err`=0.
  - State IDLE, buffer empty.
- Pin-to-detection latency is `SYNC_STAGES`+1 cycles.
- `rx_valid` asserts `SYNC_STAGES`+2 cycles after the 8th sample edge at the pin.
- cpha=0: bit 7 must be on `miso_out` by `SYNC_STAGES`+2 cycles after the CS falling edge. The master must allow at least that much CS-to-first-edge setup.
- Simultaneous events:
  - Buffer load and `tx_valid` in the same cycle: the load takes the old content; the new byte is accepted the next cycle.
  - CS rise and the 8th sample detected in the same cycle: the byte completes (`rx_valid` pulses) and `frame_err` stays 0.
- `rst_n` low mid-frame returns everything to reset values immediately. Resynchronization starts after release.

## Structure
- Package `spi_pkg`:
  - state enum (IDLE, ACTIVE)
  - `SPI_BYTE_W`=8
  - mode encoding shared with `spi_master`
- Sub-module `spi_sync_edge`: N-stage synchronizer with rise/fall pulse outputs. Instantiated for SCK and CS; MOSI uses the synchronizer only.

## Test plan
- Mode 0, master sends 0xA5 while buffer holds 0x3C → `rx_data`=0xA5 with one `rx_valid` pulse; master receives 0x3C.
- Mode 3, two-byte frame 0x12,0x34; `tx_valid` supplies 0xF0 after the first byte starts → received in order; MISO returns 0x(buffer),0xF0; `tx_ready` toggles once per byte.
- Mode 1, empty buffer at CS assertion → MISO shifts 0x00; `tx_underrun` pulses once.
- Mode 2, CS deasserted after 5 bits → `frame_err` pulse, no `rx_valid`, `busy`=0, `miso_oe`=0.
- `rst_n` asserted mid-byte in mode 0, then a clean frame 0x81 → all outputs at reset values during reset; 0x81 received correctly afterwards.
- SCK toggling with CS high → no `rx_valid`; `miso_oe` stays 0.
